// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 arbiter with a registered output stage.
// Optional packet lock: define MUX2_ARB_PKT_LOCK_EN.
module mux2_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_sel
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_sel_q, out_sel_d;
    logic             pri_q, pri_d;

    logic load;
    logic gnt_a;
    logic gnt_b;
    logic acc;
    logic acc_last;

`ifdef MUX2_ARB_PKT_LOCK_EN
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
`endif

    // Reset gates load so no requester sees ready while rst is high.
    assign load = !rst && (!out_valid_q || out_ready);

    always_comb begin
        gnt_a = a_valid && (!b_valid || !pri_q);
        gnt_b = b_valid && (!a_valid || pri_q);
`ifdef MUX2_ARB_PKT_LOCK_EN
        if (state_q == LOCKED) begin
            gnt_a = !owner_q && a_valid;
            gnt_b = owner_q && b_valid;
        end
`endif
    end

    assign a_ready  = load && gnt_a;
    assign b_ready  = load && gnt_b;
    assign acc      = a_ready || b_ready;
    assign acc_last = b_ready ? b_last : a_last;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        pri_d       = pri_q;
`ifdef MUX2_ARB_PKT_LOCK_EN
        state_d     = state_q;
        owner_d     = owner_q;
`endif
        if (load) begin
            out_valid_d = acc;
        end
        if (acc) begin
            out_data_d = b_ready ? b_data : a_data;
            out_last_d = acc_last;
            out_sel_d  = b_ready;
`ifdef MUX2_ARB_PKT_LOCK_EN
            if (state_q == UNLOCKED) begin
                if (!acc_last) begin
                    state_d = LOCKED;
                    owner_d = b_ready;
                end else begin
                    pri_d = !b_ready;
                end
            end else if (acc_last) begin
                state_d = UNLOCKED;
                pri_d   = !owner_q;
            end
`else
            pri_d = !b_ready;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 1'b0;
            pri_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
            pri_q       <= pri_d;
        end
    end

`ifdef MUX2_ARB_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCKED;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios plus random traffic
// checked against a behavioural model (honours MUX2_ARB_PKT_LOCK_EN).
module tb_mux2_rr_arbiter;

`ifdef MUX2_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_ready, a_last;
    logic [7:0] a_data;
    logic       b_valid, b_ready, b_last;
    logic [7:0] b_data;
    logic       out_valid, out_ready, out_last, out_sel;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_last   (a_last),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_last   (b_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_sel  (out_sel)
    );

    int checks = 0;
    int passes = 0;

    bit       mv, ml, ms, mpri, mlock, mown;
    bit [7:0] md;
    bit       macc_a, macc_b;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            passes++;
    endtask

    // Which requester the rules pick this cycle: -1 none, 0 a, 1 b.
    function automatic int winner();
        if (LOCK && mlock) begin
            if (mown == 1'b0) return a_valid ? 0 : -1;
            return b_valid ? 1 : -1;
        end
        if (a_valid && b_valid) return int'(mpri);
        if (a_valid) return 0;
        if (b_valid) return 1;
        return -1;
    endfunction

    function automatic bit mload();
        return !rst && (!mv || out_ready);
    endfunction

    task automatic model_check();
        int w;
        w = winner();
        chk("a_ready", a_ready, 32'(mload() && w == 0));
        chk("b_ready", b_ready, 32'(mload() && w == 1));
        chk("out_valid", out_valid, 32'(mv));
        chk("out_data", out_data, 32'(md));
        chk("out_last", out_last, 32'(ml));
        chk("out_sel", out_sel, 32'(ms));
    endtask

    task automatic model_update();
        int w;
        bit x, lst;
        macc_a = 1'b0;
        macc_b = 1'b0;
        if (rst) begin
            mv = 0; md = 0; ml = 0; ms = 0;
            mpri = 0; mlock = 0; mown = 0;
        end else if (mload()) begin
            w = winner();
            if (w < 0) begin
                mv = 0;
            end else begin
                x   = (w == 1);
                lst = x ? b_last : a_last;
                mv  = 1;
                md  = x ? b_data : a_data;
                ml  = lst;
                ms  = x;
                macc_a = !x;
                macc_b = x;
                if (LOCK) begin
                    if (!mlock) begin
                        if (!lst) begin
                            mlock = 1;
                            mown  = x;
                        end else begin
                            mpri = !x;
                        end
                    end else if (lst) begin
                        mlock = 0;
                        mpri  = !x;
                    end
                end else begin
                    mpri = !x;
                end
            end
        end
    endtask

    task automatic cycle();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] fd[5];
        bit         fs[5];
        bit         lk_on[5];
        bit         lk_off[5];
        int         ai;
        fd     = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h11};
        fs     = '{0, 1, 0, 1, 0};
        lk_on  = '{0, 0, 0, 1, 1};
        lk_off = '{0, 1, 0, 1, 0};

        rst = 1; out_ready = 1;
        a_valid = 1; a_data = 8'h11; a_last = 1;
        b_valid = 1; b_data = 8'h22; b_last = 1;
        @(posedge clk);
        model_update();
        @(negedge clk);

        repeat (2) begin
            #1;
            chk("rst_a_ready", a_ready, 0);
            chk("rst_b_ready", b_ready, 0);
            cycle();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_sel", out_sel, 0);
        end
        rst = 0;

        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("fair_data", out_data, 32'(fd[i]));
            chk("fair_sel", out_sel, 32'(fs[i]));
        end

        out_ready = 0;
        repeat (2) begin
            #1;
            chk("bp_a_ready", a_ready, 0);
            chk("bp_b_ready", b_ready, 0);
            cycle();
            chk("bp_hold_data", out_data, 32'h11);
            chk("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1;
        cycle();
        chk("bp_release_data", out_data, 32'h22);
        chk("bp_release_sel", out_sel, 1);

        a_valid = 0;
        for (int i = 0; i < 4; i++) begin
            b_data = 8'(8'h30 + i);
            cycle();
            chk("single_data", out_data, 32'(8'h30 + i));
            chk("single_sel", out_sel, 1);
            chk("single_valid", out_valid, 1);
        end

        b_valid = 0; a_valid = 1; a_data = 8'h44;
        cycle();
        chk("pre_rst_sel", out_sel, 0);
        b_valid = 1; rst = 1;
        cycle();
        chk("mid_rst_valid", out_valid, 0);
        rst = 0; a_data = 8'h55; b_data = 8'h66;
        cycle();
        chk("post_rst_sel", out_sel, 0);
        chk("post_rst_data", out_data, 32'h55);

        rst = 1;
        cycle();
        rst = 0;
        ai = 0;
        a_valid = 1; a_data = 8'hA0; a_last = 0;
        b_valid = 1; b_data = 8'hBB; b_last = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("lock_seq", out_sel, LOCK ? 32'(lk_on[i]) : 32'(lk_off[i]));
            if (macc_a) begin
                ai++;
                if (ai == 3) a_valid = 0;
                a_data = 8'(8'hA0 + ai);
                a_last = (ai == 2);
            end
        end

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!a_valid || macc_a || rst) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_data  = 8'($urandom);
                a_last  = ($urandom_range(0, 2) == 0);
            end
            if (!b_valid || macc_b || rst) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_data  = 8'($urandom);
                b_last  = ($urandom_range(0, 2) == 0);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
